// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared Wishbone types and default bus geometry
package wb_pkg;

  // Default bus geometry, shared with the register slaves
  localparam int WB_ADDR_WIDTH = 3;
  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_GRANULE    = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_RESP
  } wb_state_e;

  typedef enum logic [1:0] {
    RSP_OK,
    RSP_ERR,
    RSP_TIMEOUT
  } wb_status_e;

endpackage

// File: rtl/wb_timeout_cnt.sv
// rtl/wb_timeout_cnt.sv - saturating cycle counter with clear, enable and expiry flag
module wb_timeout_cnt #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  // Last count value before expiry; a LIMIT of 0 never expires
  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Clear wins over enable; counting stops at all-ones instead of wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (LIMIT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/wb_initiator.sv
// rtl/wb_initiator.sv - Wishbone classic single-transfer initiator
module wb_initiator
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = WB_DATA_WIDTH,
  parameter int GRANULE        = WB_GRANULE,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int SEL_WIDTH     = DATA_WIDTH / GRANULE
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [DATA_WIDTH-1:0] cmd_dat_i,
  input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [SEL_WIDTH-1:0]  sel_o,
  output logic                  we_o,
  output logic                  stb_o,
  output logic                  cyc_o,
  input  logic                  ack_i,
  input  logic                  err_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  wb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic                  we_q, we_d;
  logic                  cyc_q, cyc_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_to_q, rsp_to_d;
  logic                  cnt_clr, cnt_en, cnt_expired;
  logic                  done;
  wb_status_e            status;

  wb_timeout_cnt #(
    .WIDTH (CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .expired_o (cnt_expired)
  );

  // Next-state and register updates; everything holds unless a transition says otherwise
  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    we_d        = we_q;
    cyc_d       = cyc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    rsp_to_d    = rsp_to_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    done        = 1'b0;
    status      = RSP_OK;
    unique case (state_q)
      ST_IDLE: begin
        // cmd_ready_o is high throughout IDLE, so valid alone is the handshake
        if (cmd_valid_i) begin
          adr_d   = cmd_adr_i;
          dat_d   = cmd_we_i ? cmd_dat_i : '0;
          sel_d   = cmd_sel_i;
          we_d    = cmd_we_i;
          cyc_d   = 1'b1;
          cnt_clr = 1'b1;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        cnt_en = 1'b1;
        // err dominates ack; a slave answer in the expiry cycle still beats the timeout
        if (err_i) begin
          done   = 1'b1;
          status = RSP_ERR;
        end else if (ack_i) begin
          done   = 1'b1;
          status = RSP_OK;
        end else if (cnt_expired) begin
          done   = 1'b1;
          status = RSP_TIMEOUT;
        end
        if (done) begin
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = (status != RSP_OK);
          rsp_to_d    = (status == RSP_TIMEOUT);
          rsp_dat_d   = ((status == RSP_OK) && !we_q) ? dat_i : '0;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        // Returning to IDLE here guarantees an idle bus cycle before the next command
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops the bus immediately and discards any response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      cyc_q       <= cyc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
    end
  end

  assign cmd_ready_o   = (state_q == ST_IDLE);
  assign adr_o         = adr_q;
  assign dat_o         = dat_q;
  assign sel_o         = sel_q;
  assign we_o          = we_q;
  assign cyc_o         = cyc_q;
  assign stb_o         = cyc_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_dat_o     = rsp_dat_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_to_q;

endmodule

// File: tb/tb_wb_initiator.sv
// tb/tb_wb_initiator.sv - self-checking bench for wb_initiator
module tb_wb_initiator;

  localparam int TMO = 16;

  typedef struct {
    bit          we;
    logic [2:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    bit          ack_en;
    bit          err_en;
    int          ws;
    logic [31:0] rdata;
    int          rdy;
    bit          late;
    int          e_len;
    bit          e_err;
    bit          e_to;
    logic [31:0] e_dat;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [2:0]  cmd_adr_i = '0;
  logic [31:0] cmd_dat_i = '0;
  logic [3:0]  cmd_sel_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic [2:0]  adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic [3:0]  sel_o;
  logic        we_o;
  logic        stb_o;
  logic        cyc_o;
  logic        ack_i;
  logic        err_i;

  int          passed = 0;
  int          total = 0;

  bit          slv_ack_en = 1'b0;
  bit          slv_err_en = 1'b0;
  int          slv_ws = 0;
  logic [31:0] slv_rdata = '0;
  logic        force_ack = 1'b0;
  int          slv_cnt = 0;

  wb_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .sel_o(sel_o), .we_o(we_o),
    .stb_o(stb_o), .cyc_o(cyc_o), .ack_i(ack_i), .err_i(err_i)
  );

  always #5 clk_i = ~clk_i;

  // Slave: answers in BUS cycle slv_ws (0 = combinationally in the first cycle)
  always @(posedge clk_i) slv_cnt <= cyc_o ? slv_cnt + 1 : 0;
  assign ack_i = force_ack | (cyc_o & stb_o & slv_ack_en & (slv_cnt == slv_ws));
  assign err_i = cyc_o & stb_o & slv_err_en & (slv_cnt == slv_ws);
  assign dat_i = slv_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input bit we, input logic [2:0] adr, input logic [31:0] dat,
                              input logic [3:0] sel, input bit ack_en, input bit err_en,
                              input int ws, input logic [31:0] rdata, input int rdy, input bit late,
                              input int e_len, input bit e_err, input bit e_to, input logic [31:0] e_dat);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.ack_en = ack_en; v.err_en = err_en;
    v.ws = ws; v.rdata = rdata; v.rdy = rdy; v.late = late;
    v.e_len = e_len; v.e_err = e_err; v.e_to = e_to; v.e_dat = e_dat;
    return v;
  endfunction

  // Transaction-level reference: how the transfer must end, judged from the slave's behaviour
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (!(v.ack_en || v.err_en) || v.ws >= TMO) begin
      r.e_len = TMO; r.e_err = 1'b1; r.e_to = 1'b1; r.e_dat = '0;
    end else begin
      r.e_len = v.ws + 1;
      r.e_err = v.err_en;
      r.e_to  = 1'b0;
      r.e_dat = (!v.err_en && !v.we) ? v.rdata : 32'h0;
    end
    return r;
  endfunction

  // Called one time unit after an edge with the DUT idle; leaves it idle the same way
  task automatic do_txn(input vec_t v, input string tag);
    int          len;
    bit          stable;
    bit          held;
    logic [31:0] exp_dat_o;
    logic [31:0] d0;
    logic        e0, t0;
    slv_ack_en = v.ack_en; slv_err_en = v.err_en; slv_ws = v.ws; slv_rdata = v.rdata;
    force_ack = 1'b0; rsp_ready_i = 1'b0;
    exp_dat_o = v.we ? v.dat : 32'h0;
    chk({tag, " cmd_ready_idle"}, cmd_ready_o, 1'b1);
    cmd_valid_i = 1'b1; cmd_we_i = v.we; cmd_adr_i = v.adr; cmd_dat_i = v.dat; cmd_sel_i = v.sel;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0; cmd_dat_i = $urandom; cmd_adr_i = 3'($urandom); cmd_we_i = 1'($urandom);
    chk({tag, " cyc_rise"}, cyc_o, 1'b1);
    len = 0; stable = 1'b1;
    while (cyc_o && len < 40) begin
      if (adr_o !== v.adr || dat_o !== exp_dat_o || sel_o !== v.sel || we_o !== v.we ||
          stb_o !== 1'b1 || rsp_valid_o !== 1'b0)
        stable = 1'b0;
      len++;
      @(posedge clk_i); #1;
    end
    chk({tag, " cyc_len"}, len, v.e_len);
    chk({tag, " bus_stable"}, stable, 1'b1);
    chk({tag, " stb_we_low"}, {stb_o, we_o}, 2'b00);
    chk({tag, " rsp_valid"}, rsp_valid_o, 1'b1);
    chk({tag, " rsp_dat"}, rsp_dat_o, v.e_dat);
    chk({tag, " rsp_err"}, rsp_err_o, v.e_err);
    chk({tag, " rsp_timeout"}, rsp_timeout_o, v.e_to);
    d0 = rsp_dat_o; e0 = rsp_err_o; t0 = rsp_timeout_o;
    cmd_valid_i = 1'b1; cmd_sel_i = 4'($urandom);
    force_ack = v.late;
    held = 1'b1;
    for (int i = 0; i < v.rdy; i++) begin
      @(posedge clk_i); #1;
      if (rsp_valid_o !== 1'b1 || rsp_dat_o !== d0 || rsp_err_o !== e0 ||
          rsp_timeout_o !== t0 || cmd_ready_o !== 1'b0 || cyc_o !== 1'b0)
        held = 1'b0;
    end
    if (v.rdy > 0) chk({tag, " rsp_hold"}, held, 1'b1);
    force_ack = 1'b0;
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    chk({tag, " after_hs"}, {rsp_valid_o, cyc_o, cmd_ready_o}, 3'b001);
    cmd_valid_i = 1'b0;
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = mk(0, 3'b010, 32'h0,        4'hF, 1, 0, 0,  32'h00000002, 0, 0, 1,  0, 0, 32'h00000002);
    tbl[1] = mk(1, 3'b100, 32'hDEADBEEF, 4'h5, 1, 0, 3,  32'hFFFFFFFF, 0, 0, 4,  0, 0, 32'h0);
    tbl[2] = mk(0, 3'b001, 32'h0,        4'hF, 0, 0, 0,  32'hCAFEF00D, 3, 1, 16, 1, 1, 32'h0);
    tbl[3] = mk(0, 3'b011, 32'h0,        4'hF, 1, 1, 0,  32'h12345678, 0, 0, 1,  1, 0, 32'h0);
    tbl[4] = mk(0, 3'b110, 32'h0,        4'h3, 1, 0, 1,  32'hA5A55A5A, 5, 0, 2,  0, 0, 32'hA5A55A5A);
    tbl[5] = mk(0, 3'b111, 32'h0,        4'hF, 1, 0, 15, 32'h0BADCAFE, 0, 0, 16, 0, 0, 32'h0BADCAFE);
    tbl[6] = mk(0, 3'b000, 32'h0,        4'hF, 1, 0, 16, 32'h11111111, 1, 0, 16, 1, 1, 32'h0);
    tbl[7] = mk(1, 3'b101, 32'h87654321, 4'hC, 0, 1, 2,  32'h22222222, 0, 0, 3,  1, 0, 32'h0);
    tbl[8] = mk(0, 3'b010, 32'h0,        4'h1, 0, 1, 2,  32'h33333333, 1, 0, 3,  1, 0, 32'h0);
    tbl[9] = mk(1, 3'b011, 32'h00C0FFEE, 4'hF, 1, 0, 0,  32'h44444444, 2, 0, 1,  0, 0, 32'h0);

    // Reset state
    #1 rst_i = 1'b1;
    #1;
    chk("rst_bus", {cyc_o, stb_o, we_o}, 3'b000);
    chk("rst_rsp", {rsp_valid_o, rsp_err_o, rsp_timeout_o}, 3'b000);
    chk("rst_adr_sel", {adr_o, sel_o}, 7'h0);
    chk("rst_dat_o", dat_o, 32'h0);
    chk("rst_rsp_dat", rsp_dat_o, 32'h0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk("rst_cmd_ready", cmd_ready_o, 1'b1);

    // Directed table
    for (int i = 0; i < 10; i++) do_txn(tbl[i], $sformatf("tbl%0d", i));

    // Reset in the middle of a transfer, between clock edges
    slv_ack_en = 1'b0; slv_err_en = 1'b0;
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 3'b101; cmd_dat_i = 32'h5555AAAA; cmd_sel_i = 4'hF;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #3;
    chk("midrst_cyc_before", cyc_o, 1'b1);
    rst_i = 1'b1;
    #1;
    chk("midrst_cyc_stb", {cyc_o, stb_o}, 2'b00);
    chk("midrst_rsp_valid", rsp_valid_o, 1'b0);
    #2 rst_i = 1'b0;
    @(posedge clk_i); #1;
    chk("midrst_after", {cmd_ready_o, rsp_valid_o, cyc_o}, 3'b100);
    do_txn(tbl[0], "post_rst");

    // Randomised transfers against the reference model
    for (int n = 0; n < 40; n++) begin
      vec_t v;
      int   k;
      v.we = 1'($urandom); v.adr = 3'($urandom); v.dat = $urandom; v.sel = 4'($urandom);
      k = $urandom_range(0, 9);
      v.ack_en = (k < 6) || (k == 8);
      v.err_en = (k == 6) || (k == 7) || (k == 8);
      v.ws = (k == 9 && $urandom_range(0, 1) == 1) ? 20 : $urandom_range(0, 5);
      v.rdata = $urandom; v.rdy = $urandom_range(0, 3); v.late = 1'($urandom);
      do_txn(model(v), $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
